// File: rtl/rob_retire_pkg.sv
// Shared sizes, ROB entry layout and the freed-tag selection rule.
package rob_retire_pkg;
  localparam int DEPTH   = 64;
  localparam int IDX_W   = 6;
  localparam int PREG_W  = 6;
  localparam int AREG_W  = 5;
  localparam int NUM_CMP = 3;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              reg_wr;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] rd_new;
    logic [PREG_W-1:0] rd_old;
  } rob_entry_t;

  // x0 is never mapped, so its freshly popped tag goes straight back to the pool.
  function automatic logic [PREG_W-1:0] free_tag(input rob_entry_t e);
    if (!e.reg_wr)          return '0;
    else if (e.areg == '0)  return e.rd_new;
    else                    return e.rd_old;
  endfunction
endpackage

// File: rtl/rob_retire_ptr.sv
// Wrap-bit circular pointer: index in the low bits, lap parity in the MSB.
module rob_retire_ptr #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);
  logic [W-1:0] r_ptr;

  // Advance by one on enable; natural overflow toggles the wrap bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/rob_retire.sv
// Reorder buffer: allocate at tail, mark done from FU ports, retire in order at head.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_alloc_valid,
  output logic                     o_alloc_ready,
  input  logic                     i_alloc_reg_wr,
  input  logic [AREG_W-1:0]        i_alloc_areg,
  input  logic [PREG_W-1:0]        i_alloc_rd_new,
  input  logic [PREG_W-1:0]        i_alloc_rd_old,
  output logic [IDX_W-1:0]         o_alloc_idx,
  input  logic [NUM_CMP-1:0]       i_cmp_valid,
  input  logic [NUM_CMP*IDX_W-1:0] i_cmp_idx,
  output logic                     o_push_free_reg,
  output logic [PREG_W-1:0]        o_freed_reg,
  output logic                     o_commit_valid,
  output logic                     o_commit_reg_wr,
  output logic [AREG_W-1:0]        o_commit_areg,
  output logic [PREG_W-1:0]        o_commit_preg,
  output logic [IDX_W:0]           o_count,
  output logic                     o_empty,
  output logic                     o_full
);
  logic [IDX_W:0]     w_head, w_tail;
  logic [IDX_W-1:0]   w_hidx, w_tidx;
  logic               w_full, w_alloc, w_retire;
  logic [DEPTH-1:0]   w_cmp_hit;
  rob_entry_t         w_head_e;
  rob_entry_t         r_rob [DEPTH];

  logic               r_commit_valid, r_commit_reg_wr, r_push;
  logic [AREG_W-1:0]  r_commit_areg;
  logic [PREG_W-1:0]  r_commit_preg, r_freed;

  assign w_hidx   = w_head[IDX_W-1:0];
  assign w_tidx   = w_tail[IDX_W-1:0];
  assign w_full   = (w_hidx == w_tidx) && (w_head[IDX_W] != w_tail[IDX_W]);
  assign w_alloc  = i_alloc_valid && !w_full;
  assign w_head_e = r_rob[w_hidx];
  assign w_retire = w_head_e.valid && w_head_e.done;

  rob_retire_ptr #(.W(IDX_W+1)) u_head (.clk(clk), .rst(rst), .i_inc(w_retire), .o_ptr(w_head));
  rob_retire_ptr #(.W(IDX_W+1)) u_tail (.clk(clk), .rst(rst), .i_inc(w_alloc),  .o_ptr(w_tail));

  // Decode completion ports into a per-entry hit vector; duplicate indices merge.
  always_comb begin
    w_cmp_hit = '0;
    for (int k = 0; k < NUM_CMP; k++)
      if (i_cmp_valid[k]) w_cmp_hit[i_cmp_idx[k*IDX_W +: IDX_W]] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    // Entry update: alloc writes, retire clears, completion sets done on live entries.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rob[g] <= '0;
      end else if (w_alloc && w_tidx == IDX_W'(g)) begin
        r_rob[g] <= '{valid: 1'b1, done: 1'b0, reg_wr: i_alloc_reg_wr, areg: i_alloc_areg,
                      rd_new: i_alloc_rd_new, rd_old: i_alloc_rd_old};
      end else if (w_retire && w_hidx == IDX_W'(g)) begin
        r_rob[g].valid <= 1'b0;
        r_rob[g].done  <= 1'b0;
      end else if (w_cmp_hit[g] && r_rob[g].valid) begin
        r_rob[g].done  <= 1'b1;
      end
    end
  end

  // Registered commit/free outputs for the entry leaving the head this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_valid  <= 1'b0;
      r_commit_reg_wr <= 1'b0;
      r_commit_areg   <= '0;
      r_commit_preg   <= '0;
      r_push          <= 1'b0;
      r_freed         <= '0;
    end else if (w_retire) begin
      r_commit_valid  <= 1'b1;
      r_commit_reg_wr <= w_head_e.reg_wr;
      r_commit_areg   <= w_head_e.areg;
      r_commit_preg   <= w_head_e.rd_new;
      r_push          <= w_head_e.reg_wr;
      r_freed         <= free_tag(w_head_e);
    end else begin
      r_commit_valid  <= 1'b0;
      r_commit_reg_wr <= 1'b0;
      r_commit_areg   <= '0;
      r_commit_preg   <= '0;
      r_push          <= 1'b0;
      r_freed         <= '0;
    end
  end

  assign o_alloc_ready   = !w_full;
  assign o_alloc_idx     = w_tidx;
  assign o_count         = w_tail - w_head;
  assign o_empty         = (w_head == w_tail);
  assign o_full          = w_full;
  assign o_commit_valid  = r_commit_valid;
  assign o_commit_reg_wr = r_commit_reg_wr;
  assign o_commit_areg   = r_commit_areg;
  assign o_commit_preg   = r_commit_preg;
  assign o_push_free_reg = r_push;
  assign o_freed_reg     = r_freed;
endmodule

// File: tb/tb_rob_retire.sv
// Directed bench with a commit scoreboard checked by an independent monitor.
module tb_rob_retire;
  import rob_retire_pkg::*;

  logic                     clk = 1'b0, rst = 1'b1;
  logic                     alloc_valid = 1'b0, alloc_ready, alloc_reg_wr = 1'b0;
  logic [AREG_W-1:0]        alloc_areg = '0;
  logic [PREG_W-1:0]        alloc_rd_new = '0, alloc_rd_old = '0;
  logic [IDX_W-1:0]         alloc_idx;
  logic [NUM_CMP-1:0]       cmp_valid = '0;
  logic [NUM_CMP*IDX_W-1:0] cmp_idx = '0;
  logic                     push_free_reg, commit_valid, commit_reg_wr, empty, full;
  logic [PREG_W-1:0]        freed_reg, commit_preg;
  logic [AREG_W-1:0]        commit_areg;
  logic [IDX_W:0]           count;

  typedef struct {
    logic              reg_wr;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic              push;
    logic [PREG_W-1:0] freed;
  } exp_t;

  exp_t m_exp [DEPTH];
  exp_t sb_q [$];
  int   m_tail = 0;
  int   checks = 0, fails = 0;

  rob_retire dut (
    .clk(clk), .rst(rst),
    .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready), .i_alloc_reg_wr(alloc_reg_wr),
    .i_alloc_areg(alloc_areg), .i_alloc_rd_new(alloc_rd_new), .i_alloc_rd_old(alloc_rd_old),
    .o_alloc_idx(alloc_idx), .i_cmp_valid(cmp_valid), .i_cmp_idx(cmp_idx),
    .o_push_free_reg(push_free_reg), .o_freed_reg(freed_reg), .o_commit_valid(commit_valid),
    .o_commit_reg_wr(commit_reg_wr), .o_commit_areg(commit_areg), .o_commit_preg(commit_preg),
    .o_count(count), .o_empty(empty), .o_full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hand-written freeing rule: areg x0 returns rd_new, stores return nothing.
  function automatic exp_t mk(input logic wr, input int a, input int nw, input int od);
    exp_t e;
    e.reg_wr = wr; e.areg = AREG_W'(a); e.preg = PREG_W'(nw);
    e.push   = wr;
    e.freed  = !wr ? '0 : (a == 0 ? PREG_W'(nw) : PREG_W'(od));
    return e;
  endfunction

  task automatic alloc(input logic wr, input int a, input int nw, input int od);
    chk("alloc_idx", 32'(alloc_idx), 32'(m_tail));
    m_exp[m_tail] = mk(wr, a, nw, od);
    m_tail = (m_tail + 1) % DEPTH;
    alloc_valid = 1'b1; alloc_reg_wr = wr;
    alloc_areg = AREG_W'(a); alloc_rd_new = PREG_W'(nw); alloc_rd_old = PREG_W'(od);
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cmp(input int port, input int idx);
    cmp_valid = '0;
    cmp_valid[port] = 1'b1;
    cmp_idx[port*IDX_W +: IDX_W] = IDX_W'(idx);
    tick();
    cmp_valid = '0;
  endtask

  task automatic sb_push(input int idx);
    sb_q.push_back(m_exp[idx]);
  endtask

  // Monitor: every commit must match the oldest expectation; no stray frees.
  always @(negedge clk) begin
    if (!rst && commit_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL commit_unexpected actual=preg%0d required=no_commit", commit_preg);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (commit_reg_wr !== e.reg_wr || commit_areg !== e.areg || commit_preg !== e.preg ||
            push_free_reg !== e.push || freed_reg !== e.freed) begin
          fails++;
          $display("FAIL commit_fields actual=wr%0d a%0d p%0d push%0d f%0d required=wr%0d a%0d p%0d push%0d f%0d",
                   commit_reg_wr, commit_areg, commit_preg, push_free_reg, freed_reg,
                   e.reg_wr, e.areg, e.preg, e.push, e.freed);
        end
      end
    end else if (push_free_reg) begin
      checks++; fails++;
      $display("FAIL stray_push actual=1 required=0");
    end
  end

  initial begin
    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_push", 32'(push_free_reg), 0);
    chk("rst_commit", 32'(commit_valid), 0);

    // Single instruction: x5 renamed 5 -> 63
    alloc(1'b1, 5, 63, 5);
    sb_push(0);
    cmp(0, 0);
    tick();
    chk("single_commit", 32'(commit_valid), 1);
    tick();
    chk("single_empty", 32'(empty), 1);

    // Out-of-order completion, in-order retirement (head now 1)
    alloc(1'b1, 1, 10, 20);
    alloc(1'b1, 2, 11, 21);
    alloc(1'b1, 3, 12, 22);
    cmp(1, 3);
    cmp(2, 2);
    repeat (3) tick();
    chk("ooo_hold_count", 32'(count), 3);
    sb_push(1); sb_push(2); sb_push(3);
    cmp(0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ooo_consec", 32'(commit_valid), 1);
    end
    tick();
    chk("ooo_drained", 32'(count), 0);

    // x0 write frees rd_new; store frees nothing (idx 4, 5)
    alloc(1'b1, 0, 40, 0);
    alloc(1'b0, 7, 12, 33);
    sb_push(4); sb_push(5);
    cmp_valid = 3'b011;
    cmp_idx = '0;
    cmp_idx[0 +: IDX_W] = 6'd4;
    cmp_idx[IDX_W +: IDX_W] = 6'd5;
    tick();
    cmp_valid = '0;
    repeat (3) tick();
    chk("x0_store_empty", 32'(empty), 1);

    // Fill all 64 entries starting at idx 6, wrapping through 63 -> 0
    for (int i = 0; i < DEPTH; i++) alloc(1'b1, (i % 31) + 1, i, 63 - i);
    chk("fill_full", 32'(full), 1);
    chk("fill_ready", 32'(alloc_ready), 0);
    chk("fill_count", 32'(count), 64);

    // Alloc while full is ignored
    alloc_valid = 1'b1; alloc_reg_wr = 1'b1;
    alloc_areg = 5'd9; alloc_rd_new = 6'd50; alloc_rd_old = 6'd51;
    tick();
    chk("full_ignored_count", 32'(count), 64);
    chk("full_ignored_idx", 32'(alloc_idx), 6);

    // Complete head while alloc is held: no bypass, then slot reused
    sb_push(6);
    cmp_valid = 3'b001; cmp_idx[0 +: IDX_W] = 6'd6;
    tick();
    cmp_valid = '0;
    chk("nobypass_ready", 32'(alloc_ready), 0);
    tick();
    chk("after_retire_full", 32'(full), 0);
    chk("after_retire_ready", 32'(alloc_ready), 1);
    chk("after_retire_count", 32'(count), 63);
    chk("wrap_idx", 32'(alloc_idx), 6);
    m_exp[6] = mk(1'b1, 9, 50, 51);
    m_tail = 7;
    tick();
    alloc_valid = 1'b0;
    chk("refill_full", 32'(full), 1);

    // In-order retire across head 7..15
    for (int i = 7; i < 16; i++) begin
      sb_push(i);
      cmp(0, i);
    end
    // Same index on ports 0 and 2 retires once
    sb_push(16);
    cmp_valid = 3'b101;
    cmp_idx[0 +: IDX_W] = 6'd16;
    cmp_idx[2*IDX_W +: IDX_W] = 6'd16;
    tick();
    cmp_valid = '0;
    repeat (3) tick();
    chk("dup_cmp_count", 32'(count), 54);

    // Reset while idx 17 is about to retire: nothing is committed or freed
    cmp_valid = 3'b001; cmp_idx[0 +: IDX_W] = 6'd17;
    tick();
    cmp_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_push", 32'(push_free_reg), 0);
    chk("midrst_commit", 32'(commit_valid), 0);
    chk("midrst_idx", 32'(alloc_idx), 0);
    tick(); tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst_count", 32'(count), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
